ext_mem_fetch: RTL and testbench
================================

EXT_MEM_FETCH -- requirements
Module: ext_mem_fetch

Interface
REQ-001 Parameter DEPTH, default 4, sets instruction FIFO entries; legal values are powers of two from 2 to 16.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 ext_mem_valid  output  1  read request to the external memory responder.
REQ-005 ext_mem_ready  input  1  single-cycle completion strobe from the responder; ext_mem_rdata is valid in the same cycle.
REQ-006 ext_mem_addr  output  8  word address of the current request.
REQ-007 ext_mem_rdata  input  32  read data.
REQ-008 insn_valid  output  1  FIFO head holds an instruction.
REQ-009 insn_ready  input  1  core pops the head when insn_valid && insn_ready.
REQ-010 insn_data  output  32  head instruction word.
REQ-011 insn_pc  output  8  word address the head instruction was fetched from.
REQ-012 redirect_valid  input  1  one-cycle branch/jump request; flushes the FIFO and restarts fetch.
REQ-013 redirect_pc  input  8  new fetch address, sampled when redirect_valid=1.

Function
REQ-014 Fetch FSM states: IDLE (no request), REQ (request live, response kept), DISCARD (request live, response dropped).
REQ-015 A request is live from the edge that raises ext_mem_valid until the edge that samples ext_mem_ready=1.
REQ-016 ext_mem_addr and ext_mem_valid are held stable while a request is live and ready is not yet sampled, including across redirects.
REQ-017 IDLE->REQ: on an edge where (fifo_count + live request) < DEPTH and no redirect is sampled, with ext_mem_valid=1 and ext_mem_addr=fetch_pc.
REQ-018 REQ with ready=1 sampled: rdata and ext_mem_addr are written to the FIFO and fetch_pc increments by 1, mod 256 (255->0).
REQ-019 Back-to-back: on the ready edge, if space remains after the write, ext_mem_valid stays 1 and ext_mem_addr takes the new fetch_pc; otherwise the FSM goes to IDLE with valid=0.
REQ-020 The FSM ignores ext_mem_ready=1 when no request is live.
REQ-021 Redirect sampled with no live request: FIFO flushed, fetch_pc=redirect_pc, next request issued on the following edge.
REQ-022 Redirect sampled while in REQ and ready=0: FIFO flushed, fetch_pc=redirect_pc, FSM goes to DISCARD.
REQ-023 Redirect sampled on the same edge as ready=1: the returned data is dropped, FIFO flushed, and a new request to redirect_pc starts on that edge.
REQ-024 In DISCARD, ready=1 drops the data and a request to fetch_pc is issued on that edge; a further redirect in DISCARD only updates fetch_pc.
REQ-025 Redirect takes priority over a simultaneous pop; the pop is discarded, and insn_valid=0 the cycle after the flush.
REQ-026 A simultaneous FIFO push and pop keeps the count unchanged; a pop when empty has no effect.
REQ-027 insn_data and insn_pc are driven from FIFO storage, with no combinational path from ext_mem_rdata.
REQ-028 Latency: a word accepted on edge E is visible at insn_valid after E; with a responder that answers one edge after valid, redirect to insn_valid is 2 cycles.
REQ-029 Throughput against that responder is one word per 2 cycles.

Reset
REQ-030 While rst=1: ext_mem_valid=0, ext_mem_addr=0, FSM=IDLE, fifo_count=0, insn_valid=0, insn_data=0, insn_pc=0, fetch_pc=0.
REQ-031 The first request, to address 0, is raised on the first edge with rst=0.
REQ-032 rst asserted mid-transaction: the live request is abandoned and a response arriving after reset is ignored per REQ-020.
REQ-033 rst has priority over redirect_valid and all other inputs.

Verification
REQ-034 Sequential fetch: memory[i]=i+0x100, insn_ready=1 -> insn_pc 0,1,2,... with insn_data 0x100,0x101,..., one new word every 2 cycles.
REQ-035 Backpressure: insn_ready=0 -> exactly DEPTH (4) words buffered, ext_mem_valid=0 afterwards; releasing insn_ready drains them in order, then fetch resumes.
REQ-036 Redirect to 0x40 while a request to 0x03 is live -> ext_mem_addr stays 0x03 until ready; that word is dropped; the next request is 0x40 and the first insn_pc is 0x40.
REQ-037 Redirect on the ready edge -> the returned word never appears, and ext_mem_addr=redirect_pc on the next cycle.
REQ-038 Wrap: redirect to 0xFE -> insn_pc sequence 0xFE, 0xFF, 0x00, 0x01.
REQ-039 Reset mid-request: rst for 1 cycle while valid=1 -> valid=0 during reset, the late ready is ignored, and fetch restarts at 0 with an empty FIFO.

Source files
------------

// File: rtl/ext_mem_fetch.sv
// rtl/ext_mem_fetch.sv - instruction prefetcher: external memory read FSM feeding an instruction FIFO
module ext_mem_fetch #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ext_mem_valid,
    input  logic        ext_mem_ready,
    output logic [7:0]  ext_mem_addr,
    input  logic [31:0] ext_mem_rdata,
    output logic        insn_valid,
    input  logic        insn_ready,
    output logic [31:0] insn_data,
    output logic [7:0]  insn_pc,
    input  logic        redirect_valid,
    input  logic [7:0]  redirect_pc
);

    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = PW + 1;
    localparam int CW1 = CW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [7:0]    fetch_pc, fetch_pc_n;
    logic [7:0]    addr_n;
    logic          push, flush, pop;
    logic [CW1-1:0] count_after;

    logic [31:0]   data_q [DEPTH];
    logic [7:0]    pc_q   [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;

    // A request is outstanding whenever the FSM is not idle.
    assign ext_mem_valid = (state != IDLE);
    assign insn_valid    = (count != '0);
    assign insn_data     = data_q[rd_ptr];
    assign insn_pc       = pc_q[rd_ptr];
    assign pop           = insn_valid && insn_ready;

    // Fetch FSM state, request address and fetch pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            fetch_pc     <= '0;
            ext_mem_addr <= '0;
        end else begin
            state        <= state_n;
            fetch_pc     <= fetch_pc_n;
            ext_mem_addr <= addr_n;
        end
    end

    // Next-state logic; redirect always wins over accept/pop, and a live address is never changed.
    always_comb begin
        state_n     = state;
        fetch_pc_n  = fetch_pc;
        addr_n      = ext_mem_addr;
        push        = 1'b0;
        flush       = 1'b0;
        count_after = CW1'(count) + CW1'(1) - CW1'(pop);
        case (state)
            IDLE: begin
                if (redirect_valid) begin
                    flush      = 1'b1;
                    fetch_pc_n = redirect_pc;
                end else if (count < CW'(DEPTH)) begin
                    state_n = REQ;
                    addr_n  = fetch_pc;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    flush      = 1'b1;
                    fetch_pc_n = redirect_pc;
                    if (ext_mem_ready) begin
                        addr_n = redirect_pc;
                    end else begin
                        state_n = DISCARD;
                    end
                end else if (ext_mem_ready) begin
                    push       = 1'b1;
                    fetch_pc_n = fetch_pc + 8'd1;
                    if (count_after < CW1'(DEPTH)) begin
                        addr_n = fetch_pc + 8'd1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (redirect_valid) begin
                    flush      = 1'b1;
                    fetch_pc_n = redirect_pc;
                    if (ext_mem_ready) begin
                        state_n = REQ;
                        addr_n  = redirect_pc;
                    end
                end else if (ext_mem_ready) begin
                    state_n = REQ;
                    addr_n  = fetch_pc;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Instruction FIFO; a flush drops any simultaneous push or pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= ext_mem_rdata;
                pc_q[wr_ptr]   <= ext_mem_addr;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_ext_mem_fetch.sv
// tb/tb_ext_mem_fetch.sv - scoreboard bench for ext_mem_fetch
module tb_ext_mem_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ext_mem_valid;
    logic        ext_mem_ready = 1'b0;
    logic [7:0]  ext_mem_addr;
    logic [31:0] ext_mem_rdata = '0;
    logic        insn_valid;
    logic        insn_ready = 1'b0;
    logic [31:0] insn_data;
    logic [7:0]  insn_pc;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = '0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit resp_en = 1'b0;

    logic [39:0] sb [$];
    int          fire_q [$];

    ext_mem_fetch #(.DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .ext_mem_valid (ext_mem_valid),
        .ext_mem_ready (ext_mem_ready),
        .ext_mem_addr  (ext_mem_addr),
        .ext_mem_rdata (ext_mem_rdata),
        .insn_valid    (insn_valid),
        .insn_ready    (insn_ready),
        .insn_data     (insn_data),
        .insn_pc       (insn_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Responder: answers one edge after it sees a live request, one word per request.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (resp_en) begin
                if (ext_mem_valid && !ext_mem_ready) begin
                    ext_mem_ready = 1'b1;
                    ext_mem_rdata = 32'h100 + {24'h0, ext_mem_addr};
                end else begin
                    ext_mem_ready = 1'b0;
                end
            end
        end
    end

    // Monitor: every accepted instruction is checked against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && insn_valid && insn_ready) begin
            fire_q.push_back(cyc);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_insn: got pc=%h data=%h expected none", insn_pc, insn_data);
            end else begin
                logic [39:0] e;
                e = sb.pop_front();
                check("insn_pc", {24'h0, insn_pc}, {24'h0, e[39:32]});
                check("insn_data", insn_data, e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] p;
            p = start + 8'(i);
            sb.push_back({p, 32'h100 + {24'h0, p}});
        end
    endtask

    task automatic drain(input string name);
        int k;
        insn_ready = 1'b1;
        k = 0;
        while (sb.size() != 0 && k < 300) begin
            tick();
            k++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
            sb.delete();
        end
        insn_ready = 1'b0;
    endtask

    task automatic give_ready(input logic [31:0] d);
        ext_mem_ready = 1'b1;
        ext_mem_rdata = d;
        tick();
        ext_mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        resp_en        = 1'b0;
        ext_mem_ready  = 1'b0;
        insn_ready     = 1'b0;
        redirect_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check("rst_valid", {31'h0, ext_mem_valid}, 32'h0);
        check("rst_addr", {24'h0, ext_mem_addr}, 32'h0);
        check("rst_insn_valid", {31'h0, insn_valid}, 32'h0);
        check("rst_insn_data", insn_data, 32'h0);
        check("rst_insn_pc", {24'h0, insn_pc}, 32'h0);
        rst = 1'b0;
        tick();
        check("first_req_valid", {31'h0, ext_mem_valid}, 32'h1);
        check("first_req_addr", {24'h0, ext_mem_addr}, 32'h0);
    endtask

    initial begin
        // Sequential fetch with throughput check.
        do_reset();
        fire_q.delete();
        push_exp(8'h00, 8);
        resp_en = 1'b1;
        drain("seq");
        for (int i = 1; i < 8; i++) begin
            if (i < fire_q.size())
                check("seq_spacing", 32'(fire_q[i] - fire_q[i-1]), 32'd2);
        end

        // Backpressure: exactly four words buffered, fetch stalls on 0x0B.
        repeat (30) tick();
        check("bp_valid", {31'h0, ext_mem_valid}, 32'h0);
        check("bp_addr", {24'h0, ext_mem_addr}, 32'h0B);
        check("bp_head_pc", {24'h0, insn_pc}, 32'h08);
        check("bp_head_data", insn_data, 32'h108);
        push_exp(8'h08, 6);
        drain("bp");

        // Redirect while a request to 0x03 is live.
        do_reset();
        give_ready(32'h100);
        give_ready(32'h101);
        give_ready(32'h102);
        check("live_addr3", {24'h0, ext_mem_addr}, 32'h03);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        tick();
        redirect_valid = 1'b0;
        check("rd_flush_insn_valid", {31'h0, insn_valid}, 32'h0);
        check("rd_hold_valid", {31'h0, ext_mem_valid}, 32'h1);
        check("rd_hold_addr", {24'h0, ext_mem_addr}, 32'h03);
        tick();
        check("rd_hold_addr2", {24'h0, ext_mem_addr}, 32'h03);
        give_ready(32'hDEADBEEF);
        check("rd_new_addr", {24'h0, ext_mem_addr}, 32'h40);
        check("rd_new_valid", {31'h0, ext_mem_valid}, 32'h1);
        check("rd_drop_insn_valid", {31'h0, insn_valid}, 32'h0);
        push_exp(8'h40, 3);
        resp_en = 1'b1;
        drain("rd40");

        // Redirect on the same edge as ready.
        do_reset();
        ext_mem_ready  = 1'b1;
        ext_mem_rdata  = 32'hBAD0BAD0;
        redirect_valid = 1'b1;
        redirect_pc    = 8'h80;
        tick();
        ext_mem_ready  = 1'b0;
        redirect_valid = 1'b0;
        check("rdy_rd_addr", {24'h0, ext_mem_addr}, 32'h80);
        check("rdy_rd_valid", {31'h0, ext_mem_valid}, 32'h1);
        check("rdy_rd_insn_valid", {31'h0, insn_valid}, 32'h0);
        push_exp(8'h80, 2);
        resp_en = 1'b1;
        drain("rdy_rd");

        // Address wrap after redirect to 0xFE.
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFE;
        tick();
        redirect_valid = 1'b0;
        check("wrap_flush_insn_valid", {31'h0, insn_valid}, 32'h0);
        push_exp(8'hFE, 4);
        drain("wrap");

        // Reset in the middle of a live request; late ready is ignored.
        resp_en       = 1'b0;
        ext_mem_ready = 1'b0;
        begin
            int k;
            k = 0;
            while (!ext_mem_valid && k < 20) begin
                tick();
                k++;
            end
        end
        check("mid_live_valid", {31'h0, ext_mem_valid}, 32'h1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", {31'h0, ext_mem_valid}, 32'h0);
        check("mid_rst_insn_valid", {31'h0, insn_valid}, 32'h0);
        check("mid_rst_addr", {24'h0, ext_mem_addr}, 32'h0);
        rst           = 1'b0;
        ext_mem_ready = 1'b1;
        ext_mem_rdata = 32'hBAD1BAD1;
        tick();
        ext_mem_ready = 1'b0;
        check("mid_restart_valid", {31'h0, ext_mem_valid}, 32'h1);
        check("mid_restart_addr", {24'h0, ext_mem_addr}, 32'h0);
        check("mid_late_ignored", {31'h0, insn_valid}, 32'h0);
        push_exp(8'h00, 3);
        resp_en = 1'b1;
        drain("mid_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
